// File: rtl/dma_arbiter_if.sv
// CPU-side, DMC-side and system-bus signals seen by the DMA arbiter.
// The arbiter uses the slave view; the surrounding system uses master.
interface dma_arbiter_if;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_rw_i;
    logic [7:0]  bus_data_i;
    logic        dmc_req_i;
    logic [15:0] dmc_addr_i;
    logic [15:0] bus_addr_o;
    logic [7:0]  bus_data_o;
    logic        bus_rw_o;
    logic        cpu_rdy_o;
    logic        dmc_ack_o;
    logic [7:0]  dmc_data_o;
    logic        oam_active_o;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_rw_i, bus_data_i,
        input  dmc_req_i, dmc_addr_i,
        output bus_addr_o, bus_data_o, bus_rw_o, cpu_rdy_o,
        output dmc_ack_o, dmc_data_o, oam_active_o
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_rw_i, bus_data_i,
        output dmc_req_i, dmc_addr_i,
        input  bus_addr_o, bus_data_o, bus_rw_o, cpu_rdy_o,
        input  dmc_ack_o, dmc_data_o, oam_active_o
    );
endinterface

// File: rtl/dma_arbiter.sv
// OAM sprite DMA and DMC fetch sequencer on the CPU bus; DMC steals
// get slots from OAM, everything else passes the CPU through.
module dma_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    dma_arbiter_if.slave dma
);
    localparam logic [15:0] OAMDMA  = 16'h4014;
    localparam logic [15:0] OAMDATA = 16'h2004;

    typedef enum logic [1:0] {IDLE, HALT, XFER} state_t;

    state_t     state;
    logic       get;
    logic [7:0] oam_page;
    logic [7:0] oam_cnt;
    logic [7:0] oam_buf;
    logic       oam_pend;
    logic       last_oam_get;
    logic       dmc_block;

    logic dmc_req;
    logic xfer;
    logic oam_trig;
    logic dmc_go;
    logic oam_rd;
    logic oam_wr;
    logic pend_nx;
    logic last_nx;
    logic done;

    // The requester needs one cycle to drop its level after an ack.
    assign dmc_req  = dma.dmc_req_i & ~dmc_block;
    assign xfer     = (state == XFER);
    assign oam_trig = (state == IDLE) & ~dma.cpu_rw_i
                    & (dma.cpu_addr_i == OAMDMA);
    assign dmc_go   = xfer & get & dmc_req;
    assign oam_rd   = xfer & get & ~dmc_req & oam_pend;
    assign oam_wr   = xfer & ~get & last_oam_get;

    assign pend_nx  = (oam_wr && oam_cnt == 8'hFF) ? 1'b0 : oam_pend;
    assign last_nx  = oam_rd ? 1'b1
                    : (dmc_go | oam_wr) ? 1'b0 : last_oam_get;
    assign done     = ~pend_nx & ~last_nx & ~(dmc_req & ~dmc_go);

    always_comb begin
        dma.bus_addr_o = dma.cpu_addr_i;
        dma.bus_data_o = dma.cpu_data_i;
        dma.bus_rw_o   = dma.cpu_rw_i;
        unique case (state)
            IDLE: ;
            HALT: dma.bus_rw_o = 1'b1;
            XFER: begin
                dma.bus_rw_o = 1'b1;
                unique case (1'b1)
                    dmc_go: dma.bus_addr_o = dma.dmc_addr_i;
                    oam_rd: dma.bus_addr_o = {oam_page, oam_cnt};
                    oam_wr: begin
                        dma.bus_addr_o = OAMDATA;
                        dma.bus_data_o = oam_buf;
                        dma.bus_rw_o   = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: dma.bus_rw_o = 1'b1;
        endcase
    end

    assign dma.cpu_rdy_o    = (state == IDLE);
    assign dma.dmc_ack_o    = dmc_go;
    assign dma.dmc_data_o   = dmc_go ? dma.bus_data_i : 8'h00;
    assign dma.oam_active_o = oam_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            get          <= 1'b0;
            oam_page     <= 8'h00;
            oam_cnt      <= 8'h00;
            oam_buf      <= 8'h00;
            oam_pend     <= 1'b0;
            last_oam_get <= 1'b0;
            dmc_block    <= 1'b0;
        end else begin
            get       <= ~get;
            dmc_block <= dmc_go;
            unique case (state)
                IDLE: begin
                    if (oam_trig) begin
                        oam_page <= dma.cpu_data_i;
                        oam_cnt  <= 8'h00;
                        oam_pend <= 1'b1;
                        state    <= HALT;
                    end else if (dmc_req && dma.cpu_rw_i) begin
                        state <= HALT;
                    end
                end
                HALT: state <= XFER;
                XFER: begin
                    if (oam_rd)
                        oam_buf <= dma.bus_data_i;
                    if (oam_wr)
                        oam_cnt <= oam_cnt + 8'h01;
                    oam_pend     <= pend_nx;
                    last_oam_get <= last_nx;
                    if (done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
